gcd_engine: RTL and testbench
=============================

GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 SHALL have parameter W, default 8: operand/result width in bits (W >= 2).
REQ-002 SHALL have parameter CW, default W: iteration-counter width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port init, input, 1 bit: start a new operand-entry sequence.
REQ-006 SHALL have port enter, input, 1 bit: strobe; latch `in` as the next operand.
REQ-007 SHALL have port in, input, W bits: operand value.
REQ-008 SHALL have port out, output, W bits: registered GCD result.
REQ-009 SHALL have port halt, output, 1 bit: result valid; engine idle in DONE.
REQ-010 SHALL have port busy, output, 1 bit: high only in COMPUTE.
REQ-011 SHALL have port err, output, 1 bit: both operands were zero.
REQ-012 SHALL have port iter, output, CW bits: subtraction count of the last or current run, saturating at all-ones.
REQ-013 SHALL have port state, output, 3 bits: FSM state code, exported for display and debug.

Function
REQ-014 SHALL implement FSM states IDLE=0, LOAD_A=1, LOAD_B=2, COMPUTE=3, DONE=4; codes 5-7 SHALL go to IDLE on the next edge.
REQ-015 SHALL move IDLE->LOAD_A and DONE->LOAD_A on an edge with init=1; entering LOAD_A SHALL clear halt, err and iter, and SHALL hold out.
REQ-016 SHALL, in LOAD_A with enter=1, latch A<=in and move to LOAD_B; with enter=0, SHALL stay in LOAD_A.
REQ-017 SHALL, in LOAD_B with enter=1, latch B<=in and move to COMPUTE when in!=0 and A!=0.
REQ-018 SHALL, in LOAD_B with enter=1 and (A==0 or in==0), go directly to DONE with out<=A|in, halt<=1, err<=(A==0 && in==0), iter=0.
REQ-019 SHALL perform exactly one compare/subtract per cycle in COMPUTE on the registered A and B: A>B gives A<=A-B; B>A gives B<=B-A; each subtraction increments iter (saturating).
REQ-020 SHALL, in COMPUTE when A==B, move to DONE with out<=A and halt<=1 on that edge, without incrementing iter.
REQ-021 SHALL give a latency from the B-load edge to halt=1 of iter+1 cycles.
REQ-022 SHALL hold out, halt, err and iter stable in DONE until init or reset.
REQ-023 SHALL ignore init in LOAD_A, LOAD_B and COMPUTE; SHALL ignore enter in IDLE, COMPUTE and DONE.
REQ-024 SHALL give init priority on an edge in DONE where init=1 and enter=1: go to LOAD_A and do not latch an operand.
REQ-025 SHALL perform all subtraction as W-bit unsigned arithmetic; by construction it never underflows.
REQ-026 SHALL drive busy=(state==COMPUTE) combinationally from the state register; every other output SHALL be registered.

Reset
REQ-027 SHALL, on an edge with reset=1, set state=IDLE, A=0, B=0, out=0, halt=0, err=0, iter=0, busy=0.
REQ-028 SHALL give reset precedence over init and enter in every state, including mid-COMPUTE; no partial result SHALL appear on out.

Structure
REQ-029 SHALL place the state-code localparams (IDLE..DONE) and the state width (3) in shared package gcd_pkg.
REQ-030 SHALL split the datapath (A/B registers, comparator, subtractor, zero detect) into sub-module gcd_datapath, parameterised by W; the FSM and iter counter SHALL stay in gcd_engine.

Verification
REQ-031 SHALL cover W=8, init; enter in=8; enter in=4 -> halt=1 two cycles after the B-load edge, out=4, iter=1, err=0.
REQ-032 SHALL cover W=8, operands 255 and 1 -> out=1, iter=254, halt 255 cycles after the B-load edge; busy high throughout COMPUTE.
REQ-033 SHALL cover W=8, operands 0 and 12 -> DONE on the B-load edge, out=12, err=0; operands 0 and 0 -> out=0, err=1.
REQ-034 SHALL cover reset=1 asserted mid-COMPUTE on operands 200 and 3 -> next edge state=0, out=0, halt=0, iter=0; a following run of 18 and 12 gives out=6.
REQ-035 SHALL cover init=1 and enter=1 together in DONE -> state=1, halt=0, no operand latched; init pulses during COMPUTE do not change the result.
REQ-036 SHALL cover W=16, CW=4, operands 65535 and 1 -> out=1, iter saturates at 15, halt asserted.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the subtractive GCD engine: FSM state width and codes.
package gcd_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t LOAD_A  = 3'd1;
  localparam state_t LOAD_B  = 3'd2;
  localparam state_t COMPUTE = 3'd3;
  localparam state_t DONE    = 3'd4;

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers plus the compare / subtract / zero-detect logic of the GCD engine.
// Each step_i cycle subtracts the smaller register from the larger one. When the
// registers are equal, nothing changes. Because only the larger value is ever
// reduced, the unsigned subtraction cannot underflow.
module gcd_datapath #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_a_i,
  input  logic         load_b_i,
  input  logic         step_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] a_o,
  output logic         eq_o,
  output logic         a_zero_o,
  output logic         in_zero_o
);

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         a_gt_b;
  logic         b_gt_a;

  assign a_gt_b    = (a_q > b_q);
  assign b_gt_a    = (b_q > a_q);
  assign eq_o      = (a_q == b_q);
  assign a_zero_o  = (a_q == '0);
  assign in_zero_o = (in_i == '0);
  assign a_o       = a_q;

  // Next operand values: load from the input, or take one subtraction step.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (load_a_i) a_d = in_i;
    if (load_b_i) b_d = in_i;
    if (step_i) begin
      if (a_gt_b)      a_d = a_q - b_q;
      else if (b_gt_a) b_d = b_q - a_q;
    end
  end

  // Operand registers; reset clears both.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Subtractive GCD engine. It holds the control FSM, the saturating iteration
// counter and the registered result / status outputs.
// Protocol: init is a one-cycle request that is honoured only in IDLE or DONE.
// enter is a one-cycle strobe: each enter seen in LOAD_A / LOAD_B takes in as
// the next operand. There is no back-pressure. halt=1 marks out/err/iter as
// valid, and they stay stable until the next init or reset.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic               enter,
  input  logic [W-1:0]       in,
  output logic [W-1:0]       out,
  output logic               halt,
  output logic               busy,
  output logic               err,
  output logic [CW-1:0]      iter,
  output logic [STATE_W-1:0] state
);

  state_t        state_q, state_d;
  logic [W-1:0]  out_q, out_d;
  logic          halt_q, halt_d;
  logic          err_q, err_d;
  logic [CW-1:0] iter_q, iter_d;

  logic          load_a, load_b, step;
  logic          start, zero_done, compute_done;
  logic [W-1:0]  a_val;
  logic          eq, a_zero, in_zero;

  gcd_datapath #(.W(W)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load_a_i  (load_a),
    .load_b_i  (load_b),
    .step_i    (step),
    .in_i      (in),
    .a_o       (a_val),
    .eq_o      (eq),
    .a_zero_o  (a_zero),
    .in_zero_o (in_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. Unused codes fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (init)  state_d = LOAD_A;
      LOAD_A:  if (enter) state_d = LOAD_B;
      LOAD_B:  if (enter) state_d = (a_zero || in_zero) ? DONE : COMPUTE;
      COMPUTE: if (eq)    state_d = DONE;
      DONE:    if (init)  state_d = LOAD_A;
      default:            state_d = IDLE;
    endcase
  end

  // Output / control decode and next values of the registered results.
  always_comb begin
    busy         = (state_q == COMPUTE);
    start        = ((state_q == IDLE) || (state_q == DONE)) && init;
    load_a       = (state_q == LOAD_A) && enter;
    load_b       = (state_q == LOAD_B) && enter;
    zero_done    = load_b && (a_zero || in_zero);
    compute_done = (state_q == COMPUTE) && eq;
    step         = (state_q == COMPUTE) && !eq;

    out_d  = out_q;
    halt_d = halt_q;
    err_d  = err_q;
    iter_d = iter_q;
    if (start) begin
      halt_d = 1'b0;
      err_d  = 1'b0;
      iter_d = '0;
    end
    if (zero_done) begin
      out_d  = a_val | in;
      halt_d = 1'b1;
      err_d  = a_zero && in_zero;
      iter_d = '0;
    end
    if (compute_done) begin
      out_d  = a_val;
      halt_d = 1'b1;
    end
    if (step && (iter_q != {CW{1'b1}})) begin
      iter_d = iter_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Registered result and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      halt_q <= 1'b0;
      err_q  <= 1'b0;
      iter_q <= '0;
    end else begin
      out_q  <= out_d;
      halt_q <= halt_d;
      err_q  <= err_d;
      iter_q <= iter_d;
    end
  end

  assign out   = out_q;
  assign halt  = halt_q;
  assign err   = err_q;
  assign iter  = iter_q;
  assign state = state_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine: a W=8 instance driven from a vector table
// plus corner-case sequences, and a W=16/CW=4 instance for counter saturation.
module tb_gcd_engine;
  import gcd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        init, enter;
  logic [7:0]  in8, out8, iter8;
  logic        halt8, busy8, err8;
  logic [2:0]  state8;

  logic        init16, enter16;
  logic [15:0] in16, out16;
  logic [3:0]  iter16;
  logic        halt16, busy16, err16;
  logic [2:0]  state16;

  gcd_engine #(.W(8)) dut8 (
    .clk(clk), .reset(reset), .init(init), .enter(enter), .in(in8),
    .out(out8), .halt(halt8), .busy(busy8), .err(err8), .iter(iter8), .state(state8)
  );

  gcd_engine #(.W(16), .CW(4)) dut16 (
    .clk(clk), .reset(reset), .init(init16), .enter(enter16), .in(in16),
    .out(out16), .halt(halt16), .busy(busy16), .err(err16), .iter(iter16), .state(state16)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    int         exp_iter;
    bit         exp_err;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  // ---------------- driver tasks ----------------
  // One full operation on the W=8 instance: init, enter A, enter B, wait for halt.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eo,
                      input int ei, input bit ee, input bit pulse_init);
    int lat;
    int exp_lat;
    exp_q.push_back(eo);
    exp_lat = (a == 0 || b == 0) ? 0 : ei + 1;
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    check("load_a_state", state8, LOAD_A);
    check("load_a_halt", halt8, 0);
    check("load_a_err", err8, 0);
    check("load_a_iter", iter8, 0);
    enter = 1'b1; in8 = a;
    @(negedge clk); in8 = b;
    @(negedge clk); enter = 1'b0; in8 = 8'($urandom_range(0, 255));
    lat = 0;
    while (halt8 !== 1'b1 && lat < 400) begin
      check("busy_in_compute", busy8, 1);
      if (pulse_init && lat == 1) init = 1'b1;
      @(negedge clk);
      init = 1'b0;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("out", out8, exp_q.pop_front());
    check("iter", iter8, ei);
    check("err", err8, ee);
    check("halt", halt8, 1);
    check("done_state", state8, DONE);
    check("done_busy", busy8, 0);
    enter = 1'b1; in8 = 8'd77;
    repeat (3) @(negedge clk);
    enter = 1'b0;
    check("hold_out", out8, eo);
    check("hold_iter", iter8, ei);
    check("hold_halt", halt8, 1);
    check("hold_state", state8, DONE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    vecs[0] = '{8'd8,   8'd4,   8'd4,  1,   1'b0};
    vecs[1] = '{8'd18,  8'd12,  8'd6,  2,   1'b0};
    vecs[2] = '{8'd255, 8'd1,   8'd1,  254, 1'b0};
    vecs[3] = '{8'd0,   8'd12,  8'd12, 0,   1'b0};
    vecs[4] = '{8'd0,   8'd0,   8'd0,  0,   1'b1};
    vecs[5] = '{8'd12,  8'd0,   8'd12, 0,   1'b0};
    vecs[6] = '{8'd7,   8'd7,   8'd7,  0,   1'b0};
    vecs[7] = '{8'd13,  8'd5,   8'd1,  5,   1'b0};
    vecs[8] = '{8'd100, 8'd75,  8'd25, 3,   1'b0};
    vecs[9] = '{8'd1,   8'd255, 8'd1,  254, 1'b0};

    reset = 1'b1; init = 1'b0; enter = 1'b0; in8 = '0;
    init16 = 1'b0; enter16 = 1'b0; in16 = '0;
    repeat (2) @(negedge clk);
    check("rst_state", state8, IDLE);
    check("rst_out", out8, 0);
    check("rst_halt", halt8, 0);
    check("rst_err", err8, 0);
    check("rst_iter", iter8, 0);
    check("rst_busy", busy8, 0);
    reset = 1'b0;

    // enter is ignored in IDLE
    enter = 1'b1; in8 = 8'd5;
    @(negedge clk); enter = 1'b0;
    check("idle_ignores_enter", state8, IDLE);

    for (int i = 0; i < NV; i++)
      run8(vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_iter, vecs[i].exp_err, 1'b0);

    // init pulse during COMPUTE must not disturb the run
    run8(8'd100, 8'd75, 8'd25, 3, 1'b0, 1'b1);

    // reset in the middle of COMPUTE
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0; enter = 1'b1; in8 = 8'd200;
    @(negedge clk); in8 = 8'd3;
    @(negedge clk); enter = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", busy8, 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("mid_rst_state", state8, IDLE);
    check("mid_rst_out", out8, 0);
    check("mid_rst_halt", halt8, 0);
    check("mid_rst_iter", iter8, 0);
    check("mid_rst_busy", busy8, 0);
    repeat (3) @(negedge clk);
    check("post_rst_out", out8, 0);
    run8(8'd18, 8'd12, 8'd6, 2, 1'b0, 1'b0);

    // init and enter together in DONE: init wins, nothing latched
    init = 1'b1; enter = 1'b1; in8 = 8'd99;
    @(negedge clk); init = 1'b0; enter = 1'b0;
    check("ie_state", state8, LOAD_A);
    check("ie_halt", halt8, 0);
    check("ie_iter", iter8, 0);
    check("ie_out_held", out8, 6);
    @(negedge clk);
    check("ie_still_load_a", state8, LOAD_A);
    run8(8'd20, 8'd8, 8'd4, 3, 1'b0, 1'b0);

    // W=16, CW=4: iteration counter saturates
    @(negedge clk); init16 = 1'b1;
    @(negedge clk); init16 = 1'b0; enter16 = 1'b1; in16 = 16'd65535;
    @(negedge clk); in16 = 16'd1;
    @(negedge clk); enter16 = 1'b0;
    check("w16_busy", busy16, 1);
    lat = 0;
    while (halt16 !== 1'b1 && lat < 70000) begin
      @(negedge clk);
      lat++;
    end
    check("w16_latency", lat, 65535);
    check("w16_out", out16, 1);
    check("w16_iter_sat", iter16, 15);
    check("w16_halt", halt16, 1);
    check("w16_err", err16, 0);
    check("w16_state", state16, DONE);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
